// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// Provides the default entry layout, default widths and a range helper.
package regfile_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_LO         = 0;
    localparam int RF_HI         = 31;

    // Entry at the default widths; modules with overridden
    // widths declare a same-shaped local struct.
    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Signed compare so a zero lower bound is not a constant test.
    function automatic logic rf_in_range(input int a,
                                         input int lo,
                                         input int hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/regfile_wb_match.sv
// Youngest-first priority match over the write-buffer entries.
// Ports: addrs/datas/valid per slot, rd_ptr (oldest), lkp_addr -> hit, data.
module regfile_wb_match
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] datas,
    input  logic [DEPTH-1:0]                 valid,
    input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
    input  logic [ADDR_WIDTH-1:0]            lkp_addr,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest; a later match overrides,
    // so the youngest matching entry wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && (addrs[idx] == lkp_addr)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write staging buffer in front of the register-file write port.
// Ports: CLK/RST; ENQ_* handshake in; WR_STALL, WE/ADDR_OUT/D_OUT drain;
// LKP_* forwarding lookup; COUNT/EMPTY status; ERR_RANGE/ERR_ADDR drops.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int LO         = RF_LO,
    parameter int HI         = RF_HI
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENQ_VALID,
    output logic                       ENQ_READY,
    input  logic [ADDR_WIDTH-1:0]      ENQ_ADDR,
    input  logic [DATA_WIDTH-1:0]      ENQ_DATA,
    input  logic                       WR_STALL,
    output logic                       WE,
    output logic [ADDR_WIDTH-1:0]      ADDR_OUT,
    output logic [DATA_WIDTH-1:0]      D_OUT,
    input  logic [ADDR_WIDTH-1:0]      LKP_ADDR,
    output logic                       LKP_HIT,
    output logic [DATA_WIDTH-1:0]      LKP_DATA,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       EMPTY,
    output logic                       ERR_RANGE,
    output logic [ADDR_WIDTH-1:0]      ERR_ADDR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] mem;

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  err_range_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    logic in_rng;
    logic accept;
    logic push;
    logic bad;
    logic pop;
    logic nonempty;

    logic [DEPTH-1:0]                 valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] datas;
    logic [PW-1:0]                    off;
    logic                             m_hit;
    logic [DATA_WIDTH-1:0]            m_data;

    assign nonempty  = (count_q != '0);
    assign ENQ_READY = (count_q != CW'(DEPTH)) && !RST;
    assign in_rng    = rf_in_range(int'(ENQ_ADDR), LO, HI);
    assign accept    = ENQ_VALID && ENQ_READY;
    assign push      = accept && in_rng;
    assign bad       = accept && !in_rng;

    assign WE  = nonempty && !WR_STALL && !RST;
    assign pop = WE;

    assign ADDR_OUT = nonempty ? mem[rd_ptr_q].addr : '0;
    assign D_OUT    = nonempty ? mem[rd_ptr_q].data : '0;

    // Status reads as cleared already in the reset cycle.
    assign COUNT = RST ? '0 : count_q;
    assign EMPTY = RST || !nonempty;

    assign ERR_RANGE = err_range_q;
    assign ERR_ADDR  = err_addr_q;

    // A slot is live when its distance from the head is below count.
    always_comb begin
        valid = '0;
        addrs = '0;
        datas = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - rd_ptr_q;
            valid[i] = ({1'b0, off} < count_q);
            addrs[i] = mem[i].addr;
            datas[i] = mem[i].data;
        end
    end

    regfile_wb_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_match (
        .addrs    (addrs),
        .datas    (datas),
        .valid    (valid),
        .rd_ptr   (rd_ptr_q),
        .lkp_addr (LKP_ADDR),
        .hit      (m_hit),
        .data     (m_data)
    );

    assign LKP_HIT  = m_hit && !RST;
    assign LKP_DATA = RST ? '0 : m_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_range_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_q + CW'(push) - CW'(pop);
            err_range_q <= bad;
            if (bad) err_addr_q <= ENQ_ADDR;
        end
    end

    // Payload storage needs no reset; liveness comes from count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q].addr <= ENQ_ADDR;
            mem[wr_ptr_q].data <= ENQ_DATA;
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed self-checking bench for regfile_write_buffer.
// Instance uses LO=0, HI=15 so addresses 16..31 are out of range.
module tb_regfile_write_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENQ_VALID;
    logic        ENQ_READY;
    logic [4:0]  ENQ_ADDR;
    logic [31:0] ENQ_DATA;
    logic        WR_STALL;
    logic        WE;
    logic [4:0]  ADDR_OUT;
    logic [31:0] D_OUT;
    logic [4:0]  LKP_ADDR;
    logic        LKP_HIT;
    logic [31:0] LKP_DATA;
    logic [2:0]  COUNT;
    logic        EMPTY;
    logic        ERR_RANGE;
    logic [4:0]  ERR_ADDR;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    regfile_write_buffer #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .LO         (0),
        .HI         (15)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ENQ_VALID (ENQ_VALID),
        .ENQ_READY (ENQ_READY),
        .ENQ_ADDR  (ENQ_ADDR),
        .ENQ_DATA  (ENQ_DATA),
        .WR_STALL  (WR_STALL),
        .WE        (WE),
        .ADDR_OUT  (ADDR_OUT),
        .D_OUT     (D_OUT),
        .LKP_ADDR  (LKP_ADDR),
        .LKP_HIT   (LKP_HIT),
        .LKP_DATA  (LKP_DATA),
        .COUNT     (COUNT),
        .EMPTY     (EMPTY),
        .ERR_RANGE (ERR_RANGE),
        .ERR_ADDR  (ERR_ADDR)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [4:0]  qa [12];
    logic [31:0] qd [12];

    initial begin
        RST = 1'b1; ENQ_VALID = 1'b0; ENQ_ADDR = '0; ENQ_DATA = '0;
        WR_STALL = 1'b0; LKP_ADDR = '0;
        step();
        step();
        chk("rst_we", WE, 0);
        chk("rst_ready", ENQ_READY, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_count", COUNT, 0);
        chk("rst_hit", LKP_HIT, 0);
        chk("rst_err", ERR_RANGE, 0);
        chk("rst_erraddr", ERR_ADDR, 0);

        RST = 1'b0;
        settle();
        chk("post_rst_ready", ENQ_READY, 1);

        // Single write, one-cycle latency
        ENQ_VALID = 1; ENQ_ADDR = 3; ENQ_DATA = 32'hDEADBEEF;
        LKP_ADDR = 3;
        settle();
        chk("same_cycle_nofwd", LKP_HIT, 0);
        step();
        ENQ_VALID = 0;
        settle();
        chk("t1_we", WE, 1);
        chk("t1_addr", ADDR_OUT, 3);
        chk("t1_data", D_OUT, 32'hDEADBEEF);
        chk("t1_count", COUNT, 1);
        chk("t1_fwd_head_hit", LKP_HIT, 1);
        chk("t1_fwd_head_data", LKP_DATA, 32'hDEADBEEF);
        step();
        chk("t1_empty", EMPTY, 1);
        chk("t1_we_off", WE, 0);
        chk("t1_addr0", ADDR_OUT, 0);
        chk("t1_data0", D_OUT, 0);

        // Fill under stall, then drain in order
        WR_STALL = 1;
        for (int i = 1; i <= 4; i++) begin
            ENQ_VALID = 1; ENQ_ADDR = 5'(i); ENQ_DATA = 32'h100 + i;
            step();
        end
        ENQ_VALID = 0;
        settle();
        chk("fill_count", COUNT, 4);
        chk("fill_ready", ENQ_READY, 0);
        chk("fill_we_stalled", WE, 0);
        WR_STALL = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_we", WE, 1);
            chk("drain_addr", ADDR_OUT, 64'(i + 1));
            chk("drain_data", D_OUT, 64'(32'h101 + i));
            chk("drain_ready", ENQ_READY, (i == 0) ? 1'b0 : 1'b1);
            step();
        end
        chk("drain_empty", EMPTY, 1);

        // Youngest-match forwarding with duplicates
        WR_STALL = 1;
        ENQ_VALID = 1; ENQ_ADDR = 5; ENQ_DATA = 32'h11;
        step();
        ENQ_ADDR = 5; ENQ_DATA = 32'h22;
        step();
        ENQ_ADDR = 7; ENQ_DATA = 32'h33;
        step();
        ENQ_VALID = 0;
        LKP_ADDR = 5;
        settle();
        chk("fwd_hit", LKP_HIT, 1);
        chk("fwd_young", LKP_DATA, 32'h22);
        LKP_ADDR = 6;
        settle();
        chk("fwd_miss_hit", LKP_HIT, 0);
        chk("fwd_miss_data", LKP_DATA, 0);
        LKP_ADDR = 7;
        settle();
        chk("fwd_7", LKP_DATA, 32'h33);
        WR_STALL = 0;
        LKP_ADDR = 5;
        settle();
        chk("dup_a0", ADDR_OUT, 5);
        chk("dup_d0", D_OUT, 32'h11);
        step();
        chk("dup_a1", ADDR_OUT, 5);
        chk("dup_d1", D_OUT, 32'h22);
        chk("fwd_after_pop", LKP_DATA, 32'h22);
        step();
        chk("dup_a2", ADDR_OUT, 7);
        step();
        chk("dup_empty", EMPTY, 1);

        // Range error: 20 dropped, 15 accepted
        ENQ_VALID = 1; ENQ_ADDR = 20; ENQ_DATA = 32'h55;
        settle();
        chk("rng_ready", ENQ_READY, 1);
        step();
        ENQ_VALID = 0;
        settle();
        chk("rng_err", ERR_RANGE, 1);
        chk("rng_erraddr", ERR_ADDR, 20);
        chk("rng_count", COUNT, 0);
        chk("rng_we", WE, 0);
        ENQ_VALID = 1; ENQ_ADDR = 15; ENQ_DATA = 32'h15;
        step();
        ENQ_VALID = 0;
        settle();
        chk("rng_pulse", ERR_RANGE, 0);
        chk("rng_hold", ERR_ADDR, 20);
        chk("hi_we", WE, 1);
        chk("hi_addr", ADDR_OUT, 15);
        step();
        ENQ_VALID = 1; ENQ_ADDR = 16; ENQ_DATA = 32'h16;
        step();
        ENQ_VALID = 0;
        settle();
        chk("hi1_err", ERR_RANGE, 1);
        chk("hi1_erraddr", ERR_ADDR, 16);
        chk("hi1_we", WE, 0);

        // Concurrent enqueue/dequeue with pointer wrap
        for (int k = 0; k < 12; k++) begin
            qa[k] = 5'((k * 3) % 16);
            qd[k] = 32'hC000 + k;
        end
        WR_STALL = 1;
        for (int k = 0; k < 2; k++) begin
            ENQ_VALID = 1; ENQ_ADDR = qa[k]; ENQ_DATA = qd[k];
            step();
        end
        WR_STALL = 0;
        for (int j = 0; j < 10; j++) begin
            ENQ_VALID = 1; ENQ_ADDR = qa[j+2]; ENQ_DATA = qd[j+2];
            settle();
            chk("cc_we", WE, 1);
            chk("cc_addr", ADDR_OUT, qa[j]);
            chk("cc_data", D_OUT, qd[j]);
            chk("cc_count", COUNT, 2);
            step();
        end
        ENQ_VALID = 0;
        settle();
        chk("cc_count_end", COUNT, 2);
        chk("cc_tail_a0", ADDR_OUT, qa[10]);
        chk("cc_tail_d0", D_OUT, qd[10]);
        step();
        chk("cc_tail_a1", ADDR_OUT, qa[11]);
        chk("cc_tail_d1", D_OUT, qd[11]);
        step();
        chk("cc_empty", EMPTY, 1);

        // Reset mid-operation
        WR_STALL = 1;
        for (int i = 1; i <= 3; i++) begin
            ENQ_VALID = 1; ENQ_ADDR = 5'(i); ENQ_DATA = 32'hE0 + i;
            step();
        end
        ENQ_VALID = 0;
        settle();
        chk("mr_count3", COUNT, 3);
        RST = 1; WR_STALL = 0; LKP_ADDR = 1;
        settle();
        chk("mr_we", WE, 0);
        chk("mr_ready", ENQ_READY, 0);
        chk("mr_count", COUNT, 0);
        chk("mr_empty", EMPTY, 1);
        chk("mr_hit", LKP_HIT, 0);
        step();
        RST = 0;
        settle();
        chk("mr_after_count", COUNT, 0);
        chk("mr_after_ready", ENQ_READY, 1);
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_stale_we", WE, 0);
            step();
        end
        ENQ_VALID = 1; ENQ_ADDR = 4; ENQ_DATA = 32'h44;
        step();
        ENQ_VALID = 0;
        settle();
        chk("mr_new_addr", ADDR_OUT, 4);
        chk("mr_new_data", D_OUT, 32'h44);
        step();
        chk("mr_final_empty", EMPTY, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
